// File: rtl/key_pkg.sv
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and defaults for the key click decoder:
//                FSM state encoding, default clock/window constants and a
//                constant-function ceil(log2) helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    // Burst classification states; WAIT3 is only reachable with triple-click
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT2 = 2'd1,
        ST_WAIT3 = 2'd2
    } key_state_e;

    localparam int CLK_FREQ_HZ  = 84_000_000;
    localparam int KEY_WIN_MS   = 300;
    localparam int DEF_WIN_CYC  = (CLK_FREQ_HZ / 1000) * KEY_WIN_MS;
    localparam int DEF_MODE_NUM = 4;
    localparam int DEF_MODE_W   = 2;

    // ceil(log2(value)), usable in constant expressions on any toolchain
    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_win_timer.sv
// ============================================================================
//  Module      : key_win_timer
//  Description : Clearable up-counter with a terminal-count flag that is
//                raised while the count equals WIN_CYC-1. Clear has priority
//                over enable. Also intended for long-press detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_win_timer
    import key_pkg::*;
#(
    parameter int WIN_CYC = DEF_WIN_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int              CNT_W    = clog2_f(WIN_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYC - 1);

    if (WIN_CYC < 2) begin : g_chk_win_cyc
        $error("key_win_timer: WIN_CYC must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;

    // Window counter: clear wins, otherwise count while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == CNT_LAST);

endmodule : key_win_timer

`default_nettype wire

// File: rtl/key_click_decoder.sv
// ============================================================================
//  Module      : key_click_decoder
//  Description : Classifies bursts of debounced key pulses into single /
//                double (/ triple) clicks and keeps a wrapping mode index.
//                A burst ends when a click window of WIN_CYC cycles expires
//                without a further press, or when the maximum click count is
//                reached. All outputs are registered.
//  Options     : define KEY_TRIPLE_CLICK_EN to enable triple-click detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_click_decoder
    import key_pkg::*;
#(
    parameter int WIN_CYC  = DEF_WIN_CYC,
    parameter int MODE_NUM = DEF_MODE_NUM,
    parameter int MODE_W   = DEF_MODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_vld,
    output logic              single_click,
    output logic              double_click,
    output logic              triple_click,
    output logic [MODE_W-1:0] mode
);

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

    if (MODE_W < clog2_f(MODE_NUM)) begin : g_chk_mode_w
        $error("key_click_decoder: MODE_W too narrow for MODE_NUM");
    end
    if (MODE_NUM < 2) begin : g_chk_mode_num
        $error("key_click_decoder: MODE_NUM must be at least 2");
    end
    if (WIN_CYC < 2) begin : g_chk_win_cyc
        $error("key_click_decoder: WIN_CYC must be at least 2");
    end

    key_state_e        state_q;
    logic              single_q;
    logic              double_q;
    logic [MODE_W-1:0] mode_q;
    logic              win_tc;
    logic              win_clr;
    logic              win_en;

    // Every state change happens on a key press or on terminal count (or
    // while idle), so clearing on those events restarts the window on entry
    always_comb begin
        win_en  = (state_q != ST_IDLE);
        win_clr = (state_q == ST_IDLE) || key_vld || win_tc;
    end

    key_win_timer #(
        .WIN_CYC (WIN_CYC)
    ) u_win_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (win_clr),
        .en_i  (win_en),
        .tc_o  (win_tc)
    );

`ifdef KEY_TRIPLE_CLICK_EN
    logic triple_q;

    // Burst FSM with registered pulses and mode; a press beats a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            mode_q   <= '0;
        end else begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_vld) state_q <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (key_vld) begin
                        state_q <= ST_WAIT3;
                    end else if (win_tc) begin
                        state_q  <= ST_IDLE;
                        single_q <= 1'b1;
                        mode_q   <= (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
                    end
                end
                ST_WAIT3: begin
                    if (key_vld) begin
                        state_q  <= ST_IDLE;
                        triple_q <= 1'b1;
                        mode_q   <= MODE_LAST;
                    end else if (win_tc) begin
                        state_q  <= ST_IDLE;
                        double_q <= 1'b1;
                        mode_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign triple_click = triple_q;
`else
    // Burst FSM with registered pulses and mode; a press beats a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            mode_q   <= '0;
        end else begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_vld) state_q <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (key_vld) begin
                        state_q  <= ST_IDLE;
                        double_q <= 1'b1;
                        mode_q   <= '0;
                    end else if (win_tc) begin
                        state_q  <= ST_IDLE;
                        single_q <= 1'b1;
                        mode_q   <= (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign triple_click = 1'b0;
`endif

    assign single_click = single_q;
    assign double_click = double_q;
    assign mode         = mode_q;

endmodule : key_click_decoder

`default_nettype wire

// File: tb/tb_key_click_decoder.sv
// ============================================================================
//  Module      : tb_key_click_decoder
//  Description : Self-checking bench for key_click_decoder (WIN_CYC=10,
//                MODE_NUM=4) against a deadline-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_click_decoder;

    localparam int WIN = 10;
    localparam int MN  = 4;
    localparam int MW  = 2;
`ifdef KEY_TRIPLE_CLICK_EN
    localparam int MAXC = 3;
`else
    localparam int MAXC = 2;
`endif
    // Relative edge of the double pulse for presses at 0,5 and at 0,10
    localparam int DBL_LAT5  = (MAXC == 3) ? 15 : 5;
    localparam int DBL_LAT10 = (MAXC == 3) ? 20 : 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_vld = 1'b0;
    logic          single_click;
    logic          double_click;
    logic          triple_click;
    logic [MW-1:0] mode;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: burst described by press count and window deadline
    bit m_active;
    int m_cnt;
    int m_deadline;
    bit m_s, m_d, m_t;
    int m_mode;

    always #5 clk = ~clk;

    key_click_decoder #(
        .WIN_CYC  (WIN),
        .MODE_NUM (MN),
        .MODE_W   (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_vld      (key_vld),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .mode         (mode)
    );

    function automatic void model_reset();
        m_active = 1'b0;
        m_cnt    = 0;
        m_s      = 1'b0;
        m_d      = 1'b0;
        m_t      = 1'b0;
        m_mode   = 0;
    endfunction

    function automatic void model_emit(input int n);
        if (n == 1) begin
            m_s    = 1'b1;
            m_mode = (m_mode + 1) % MN;
        end else if (n == 2) begin
            m_d    = 1'b1;
            m_mode = 0;
        end else begin
            m_t    = 1'b1;
            m_mode = MN - 1;
        end
        m_active = 1'b0;
    endfunction

    function automatic void model_edge(input bit k);
        m_s = 1'b0;
        m_d = 1'b0;
        m_t = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            if (k) begin
                m_active   = 1'b1;
                m_cnt      = 1;
                m_deadline = edge_n + WIN;
            end
        end else if (k) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MAXC) model_emit(m_cnt);
            else m_deadline = edge_n + WIN;
        end else if (edge_n == m_deadline) begin
            model_emit(m_cnt);
        end
    endfunction

    function automatic logic [4:0] got();
        return {single_click, double_click, triple_click, mode};
    endfunction

    function automatic logic [4:0] expv();
        logic [MW-1:0] mm;
        mm = m_mode[MW-1:0];
        return {m_s, m_d, m_t, mm};
    endfunction

    // One clock: drive key, let the edge sample it, advance model, settle
    task automatic tick(input bit k);
        key_vld = k;
        @(posedge clk);
        edge_n = edge_n + 1;
        model_edge(k);
        #2;
        key_vld = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== 5'b0) begin
                errors++;
                $display("FAIL reset_state edge=%0d got=%b exp=%b", edge_n, got(), 5'b0);
            end
        end
        rst_n = 1'b1;
        tick(1'b0);
        checks++;
        if (got() !== expv()) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got(), expv());
        end
    endtask

    task automatic test_single();
        int e0;
        int seen;
        seen = -1;
        tick(1'b1);
        e0 = edge_n;
        for (int i = 0; i < 14; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL single_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (single_click && seen < 0) seen = edge_n - e0;
        end
        checks++;
        if (seen !== 10) begin
            errors++;
            $display("FAIL single_latency got=%0d exp=%0d", seen, 10);
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL single_mode got=%0d exp=%0d", mode, 1);
        end
    endtask

    task automatic test_wrap_double();
        int e0;
        int seen;
        logic [MW-1:0] exp_mode;
        for (int b = 0; b < 3; b++) begin
            tick(1'b1);
            for (int i = 0; i < 12; i++) begin
                tick(1'b0);
                checks++;
                if (got() !== expv()) begin
                    errors++;
                    $display("FAIL wrap_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
                end
            end
            exp_mode = MW'((2 + b) % MN);
            checks++;
            if (mode !== exp_mode) begin
                errors++;
                $display("FAIL wrap_mode burst=%0d got=%0d exp=%0d", b, mode, exp_mode);
            end
        end
        seen = -1;
        tick(1'b1);
        e0 = edge_n;
        for (int i = 1; i <= 20; i++) begin
            tick(i == 5);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL double_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (double_click && seen < 0) seen = edge_n - e0;
        end
        checks++;
        if (seen !== DBL_LAT5 || mode !== 2'd0) begin
            errors++;
            $display("FAIL double_latency got=%0d/%0d exp=%0d/0", seen, mode, DBL_LAT5);
        end
    endtask

    task automatic test_boundary();
        int e0;
        int seen_d;
        int n_single;
        seen_d = -1;
        n_single = 0;
        tick(1'b1);
        e0 = edge_n;
        for (int i = 1; i <= 24; i++) begin
            tick(i == 10);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL tc_press_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (double_click && seen_d < 0) seen_d = edge_n - e0;
            if (single_click) n_single++;
        end
        checks++;
        if (seen_d !== DBL_LAT10 || n_single !== 0) begin
            errors++;
            $display("FAIL tc_press got=%0d/%0d exp=%0d/0", seen_d, n_single, DBL_LAT10);
        end
        n_single = 0;
        tick(1'b1);
        for (int i = 1; i <= 24; i++) begin
            tick(i == 11);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL late_press_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (single_click) n_single++;
            if (double_click) n_single = n_single + 100;
        end
        checks++;
        if (n_single !== 2) begin
            errors++;
            $display("FAIL late_press singles got=%0d exp=%0d", n_single, 2);
        end
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 4 && m_mode != 2; b++) begin
            tick(1'b1);
            for (int i = 0; i < 12; i++) tick(1'b0);
        end
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid_premode got=%0d exp=%0d", mode, 2);
        end
        tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got() !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_async got=%b exp=%b", got(), 5'b0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== 5'b0) begin
                errors++;
                $display("FAIL rst_mid_quiet edge=%0d got=%b exp=%b", edge_n, got(), 5'b0);
            end
        end
        tick(1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL rst_mid_after edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_mode got=%0d exp=%0d", mode, 1);
        end
    endtask

    task automatic test_back_to_back();
        int e1;
        int seen;
        int guard;
        seen = -1;
        guard = 0;
        tick(1'b1);
        while (!single_click && guard < 20) begin
            tick(1'b0);
            guard++;
        end
        checks++;
        if (!single_click) begin
            errors++;
            $display("FAIL b2b_first got=%b exp=%b", single_click, 1'b1);
        end
        tick(1'b1);
        e1 = edge_n;
        for (int i = 0; i < 13; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL b2b_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (single_click && seen < 0) seen = edge_n - e1;
        end
        checks++;
        if (seen !== 10) begin
            errors++;
            $display("FAIL b2b_latency got=%0d exp=%0d", seen, 10);
        end
    endtask

`ifdef KEY_TRIPLE_CLICK_EN
    task automatic test_triple();
        int e0;
        int seen;
        seen = -1;
        tick(1'b1);
        e0 = edge_n;
        for (int i = 1; i <= 14; i++) begin
            tick(i == 4 || i == 8);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL triple_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (triple_click && seen < 0) seen = edge_n - e0;
        end
        checks++;
        if (seen !== 8 || mode !== 2'd3) begin
            errors++;
            $display("FAIL triple got=%0d/%0d exp=8/3", seen, mode);
        end
        seen = -1;
        tick(1'b1);
        e0 = edge_n;
        for (int i = 1; i <= 18; i++) begin
            tick(i == 4);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL triple_dbl_cycle edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
            if (double_click && seen < 0) seen = edge_n - e0;
        end
        checks++;
        if (seen !== 14 || mode !== 2'd0) begin
            errors++;
            $display("FAIL triple_dbl got=%0d/%0d exp=14/0", seen, mode);
        end
    endtask
`endif

    task automatic test_random();
        bit k;
        for (int i = 0; i < 800; i++) begin
            k = ($urandom_range(0, 6) == 0);
            tick(k);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL random edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
        end
        for (int i = 0; i < 3 * WIN; i++) begin
            tick(1'b0);
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL random_drain edge=%0d got=%b exp=%b", edge_n, got(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_double();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
`ifdef KEY_TRIPLE_CLICK_EN
        test_triple();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_click_decoder

`default_nettype wire

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Consumes the one-cycle debounced key pulse `key_vld` from the key debounce stage.
- Classifies each press burst as a single or double click (triple click with the optional feature).
- Maintains a wrapping mode index that the edge-detection datapath uses to select its threshold/operator.
- Sits directly downstream of the debouncer, in the same 84 MHz clock domain.

Parameters:
- WIN_CYC, 25_200_000, click window in clk cycles (300 ms at 84 MHz); minimum 2.
- MODE_NUM, 4, number of modes; mode wraps MODE_NUM-1 -> 0; minimum 2.
- MODE_W, 2, width of mode output; MODE_W >= clog2(MODE_NUM).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- key_vld  input  1  debounced press pulse, one cycle wide, at most one per 20 ms.
- single_click  output  1  one-cycle pulse: burst classified single.
- double_click  output  1  one-cycle pulse: burst classified double.
- triple_click  output  1  one-cycle pulse: burst classified triple; constant 0 without the macro.
- mode  output  MODE_W  current mode index.

Behaviour:
- Reset values:
  - All outputs 0, FSM in IDLE, window counter 0.
  - Reset asserted mid-burst discards the burst; no pulse is emitted.
- All outputs are registered.
- Window counter:
  - Width clog2(WIN_CYC).
  - Cleared on every state entry.
  - Increments once per cycle while in a WAIT state.
  - Terminal condition is cnt == WIN_CYC-1.
- FSM, IDLE:
  - key_vld -> WAIT2, cnt=0.
- FSM, WAIT2:
  - key_vld on any cycle, including the terminal-count cycle -> double_click pulse on the next edge, then IDLE.
  - Key press wins over timeout when both occur in the same cycle.
  - Terminal count without key_vld -> single_click pulse, then IDLE.
  - single_click is therefore high in the cycle following edge E0+WIN_CYC, where E0 is the edge that sampled the first key_vld.
- Latency for double/triple: the pulse is high in the cycle immediately after the edge that sampled the deciding key_vld.
- key_vld in the cycle in which a pulse is being emitted (the IDLE entry cycle) starts a new burst normally.
- Pulses are mutually exclusive; exactly one pulse per burst.
- Mode update, registered on the same edge as the pulse:
  - single_click: mode <= (mode == MODE_NUM-1) ? 0 : mode+1.
  - double_click: mode <= 0.
  - triple_click: mode <= MODE_NUM-1.
- Parameter checking: elaboration fails if MODE_W < clog2(MODE_NUM) or WIN_CYC < 2.

Optional Feature:
- Macro: KEY_TRIPLE_CLICK_EN.
- With the macro defined:
  - WAIT2 + key_vld -> WAIT3, cnt cleared, no pulse yet.
  - WAIT3 + key_vld, including on terminal count -> triple_click pulse, then IDLE.
  - WAIT3 terminal count without key_vld -> double_click pulse, then IDLE.
  - Double-click latency becomes 2*WIN_CYC-ish by construction: pulse on the edge after WAIT3 terminal count.
- Without the macro:
  - WAIT3 does not exist.
  - triple_click is tied to 0.
  - Behaviour is exactly as in Behaviour above.

Decomposition:
- Shared package key_pkg holds:
  - FSM state typedef (IDLE, WAIT2, WAIT3).
  - Default constants CLK_FREQ_HZ=84_000_000 and KEY_WIN_MS=300, with derived WIN_CYC.
  - A clog2 helper function if the toolchain lacks $clog2.
- One natural sub-module, key_win_timer:
  - Clearable counter with a terminal-count flag.
  - Parameterised by WIN_CYC.
  - Reusable for long-press detection later.

Test Plan (sim with WIN_CYC=10, MODE_NUM=4):
- Single click: key_vld pulse at edge 0, no further input -> single_click high only after edge 10; mode 0 -> 1; double_click and triple_click stay 0.
- Double click and wrap:
  - Four single bursts -> mode 1, 2, 3, 0 (wrap).
  - Then pulses at edges 0 and 5 -> double_click high after edge 5 only; mode 0.
- Boundary:
  - Second key_vld exactly on the terminal-count cycle -> double_click, not single_click.
  - Second key_vld one cycle later -> single_click for the first burst and a new burst started by the second pulse.
- Reset mid-burst: rst_n low 3 cycles while in WAIT2 with mode=2 -> all outputs 0, mode 0, no pulse after release; next burst classifies normally.
- Back-to-back: a new key_vld in the cycle the single_click pulse is high -> a second burst is recognised and yields its own single_click 10 edges later.
- KEY_TRIPLE_CLICK_EN:
  - Pulses at edges 0, 4, 8 -> triple_click after edge 8; mode 3.
  - Pulses at 0, 4 only -> double_click after edge 14; mode 0.
  - Without the macro, triple_click stays 0 for all stimuli.
